setting_ctrl: RTL and testbench

- Settings-menu controller; sits directly upstream of the settings display stage.
- Turns debounced push-button levels into the menu cursor `state` and six game-setting registers.
- The display stage renders these outputs and the game core consumes them.
- Active only while `view == 0`; all values are held otherwise.

---
 rtl/setting_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_setting_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/setting_ctrl.sv
// setting_ctrl: settings-menu controller.
// Turns debounced button levels into a menu cursor and six saturating game
// settings. The menu only reacts while view == 0.
// Optional build macro SETTING_AUTOREPEAT_EN adds hold-to-repeat on up/down.
module setting_ctrl #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] view,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_back,
  output logic [2:0] state,
  output logic [2:0] player_count,
  output logic [3:0] question_count,
  output logic [6:0] answer_time,
  output logic [6:0] win_score,
  output logic [3:0] success_score,
  output logic [3:0] fail_score,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_ROOT      = 3'd0,
    ST_PLAYERS   = 3'd1,
    ST_QUESTIONS = 3'd2,
    ST_TIME      = 3'd3,
    ST_WIN       = 3'd4,
    ST_SUCCESS   = 3'd5,
    ST_FAIL      = 3'd6,
    ST_BAD       = 3'd7
  } menu_state_t;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_BACK = 3;

  logic [3:0] btn;
  logic [3:0] prev_reg;
  logic [3:0] edge_ev;
  logic [1:0] step_ev;
  logic       menu_active;

  assign btn         = {btn_back, btn_next, btn_down, btn_up};
  assign menu_active = (view == 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      // History follows the level in every view; loading 1 in reset means a
      // button held through reset must be released before it counts again.
      always_ff @(posedge clk) begin
        if (rst) prev_reg[gi] <= 1'b1;
        else     prev_reg[gi] <= btn[gi];
      end
      assign edge_ev[gi] = btn[gi] & ~prev_reg[gi] & menu_active;
    end
  endgenerate

`ifdef SETTING_AUTOREPEAT_EN
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0] rpt_ev;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_repeat
      logic [CNT_W-1:0] cnt_reg;
      logic             armed_reg;
      logic             rep_reg;
      logic             hold_ok;

      // Holding both directions, releasing, or leaving the menu stops repeat.
      assign hold_ok    = btn[gi] & menu_active & ~(btn_up & btn_down);
      assign rpt_ev[gi] = armed_reg & hold_ok &
                          (cnt_reg == (rep_reg ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES)));

      // cnt_reg counts cycles since the press or the last repeat step.
      always_ff @(posedge clk) begin
        if (rst || !hold_ok) begin
          armed_reg <= 1'b0;
          rep_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else if (edge_ev[gi]) begin
          armed_reg <= 1'b1;
          rep_reg   <= 1'b0;
          cnt_reg   <= CNT_W'(1);
        end else if (armed_reg) begin
          if (rpt_ev[gi]) begin
            rep_reg <= 1'b1;
            cnt_reg <= CNT_W'(1);
          end else begin
            cnt_reg <= CNT_W'(cnt_reg + 1'b1);
          end
        end
      end
    end
  endgenerate

  assign step_ev = edge_ev[1:0] | rpt_ev;
`else
  localparam int unused_timing = HOLD_CYCLES + REPEAT_CYCLES;
  assign step_ev = edge_ev[1:0];
`endif

  menu_state_t state_reg, state_next;
  logic        done_reg, done_next;
  logic [2:0]  pc_reg, pc_next;
  logic [3:0]  qc_reg, qc_next;
  logic [6:0]  at_reg, at_next;
  logic [6:0]  ws_reg, ws_next;
  logic [3:0]  ss_reg, ss_next;
  logic [3:0]  fs_reg, fs_next;
  logic        step_up, step_dn;

  // Saturating +/-1; bound checked first so the step never overflows.
  function automatic logic [6:0] sat_step(input logic [6:0] val, input logic [6:0] lo,
                                          input logic [6:0] hi, input logic up);
    if (up) return (val < hi) ? val + 7'd1 : val;
    else    return (val > lo) ? val - 7'd1 : val;
  endfunction

  assign step_up = step_ev[0] & ~step_ev[1];
  assign step_dn = step_ev[1] & ~step_ev[0];

  // Cursor, done pulse and settings registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ROOT;
      done_reg  <= 1'b0;
      pc_reg    <= 3'd2;
      qc_reg    <= 4'd5;
      at_reg    <= 7'd30;
      ws_reg    <= 7'd10;
      ss_reg    <= 4'd3;
      fs_reg    <= 4'd1;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      pc_reg    <= pc_next;
      qc_reg    <= qc_next;
      at_reg    <= at_next;
      ws_reg    <= ws_next;
      ss_reg    <= ss_next;
      fs_reg    <= fs_next;
    end
  end

  // Next-state: back beats next beats up/down; up/down only touch the selected setting.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    pc_next    = pc_reg;
    qc_next    = qc_reg;
    at_next    = at_reg;
    ws_next    = ws_reg;
    ss_next    = ss_reg;
    fs_next    = fs_reg;
    if (state_reg == ST_BAD) begin
      state_next = ST_ROOT;
    end else if (edge_ev[BTN_BACK]) begin
      if (state_reg == ST_ROOT) done_next  = 1'b1;
      else                      state_next = ST_ROOT;
    end else if (edge_ev[BTN_NEXT]) begin
      if (state_reg == ST_FAIL) state_next = ST_PLAYERS;
      else                      state_next = menu_state_t'(state_reg + 3'd1);
    end else if (step_up || step_dn) begin
      case (state_reg)
        ST_PLAYERS:   pc_next = 3'(sat_step(7'(pc_reg), 7'd1, 7'd4,  step_up));
        ST_QUESTIONS: qc_next = 4'(sat_step(7'(qc_reg), 7'd1, 7'd9,  step_up));
        ST_TIME:      at_next = sat_step(at_reg, 7'd5, 7'd99, step_up);
        ST_WIN:       ws_next = sat_step(ws_reg, 7'd1, 7'd99, step_up);
        ST_SUCCESS:   ss_next = 4'(sat_step(7'(ss_reg), 7'd1, 7'd9,  step_up));
        ST_FAIL:      fs_next = 4'(sat_step(7'(fs_reg), 7'd0, 7'd9,  step_up));
        default: ;
      endcase
    end
  end

  assign state          = state_reg;
  assign done           = done_reg;
  assign player_count   = pc_reg;
  assign question_count = qc_reg;
  assign answer_time    = at_reg;
  assign win_score      = ws_reg;
  assign success_score  = ss_reg;
  assign fail_score     = fs_reg;

endmodule

// File: tb/tb_setting_ctrl.sv
// Testbench for setting_ctrl: directed menu walk plus random button traffic,
// checked cycle by cycle against a behavioural menu model via a scoreboard.
module tb_setting_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] view;
  logic       btn_up, btn_down, btn_next, btn_back;
  logic [2:0] state;
  logic [2:0] player_count;
  logic [3:0] question_count;
  logic [6:0] answer_time;
  logic [6:0] win_score;
  logic [3:0] success_score;
  logic [3:0] fail_score;
  logic       done;

  always #5 clk = ~clk;

  setting_ctrl dut (
    .clk(clk), .rst(rst), .view(view),
    .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next), .btn_back(btn_back),
    .state(state), .player_count(player_count), .question_count(question_count),
    .answer_time(answer_time), .win_score(win_score), .success_score(success_score),
    .fail_score(fail_score), .done(done)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] pc;
    logic [3:0] qc;
    logic [6:0] at;
    logic [6:0] ws;
    logic [3:0] ss;
    logic [3:0] fs;
    logic       dn;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Behavioural model: cursor index, setting values, button history.
  int m_cur;
  int m_set[6];
  bit m_prev[4];
  bit m_done;
  int lo_v[6]  = '{1, 1, 5, 1, 1, 0};
  int hi_v[6]  = '{4, 9, 99, 99, 9, 9};
  int rst_v[6] = '{2, 5, 30, 10, 3, 1};

  // b = {back, next, down, up}
  function automatic void model_step(input logic [3:0] b, input logic [2:0] v, input logic r);
    bit ev[4];
    int idx;
    if (r) begin
      m_cur = 0;
      m_set = rst_v;
      for (int i = 0; i < 4; i++) m_prev[i] = 1'b1;
      m_done = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      ev[i]     = b[i] && !m_prev[i] && (v == 3'd0);
      m_prev[i] = b[i];
    end
    m_done = 1'b0;
    if (ev[3]) begin
      if (m_cur == 0) m_done = 1'b1;
      else            m_cur  = 0;
    end else if (ev[2]) begin
      m_cur = (m_cur % 6) + 1;
    end else if ((ev[0] != ev[1]) && m_cur != 0) begin
      idx = m_cur - 1;
      if (ev[0] && m_set[idx] < hi_v[idx]) m_set[idx] = m_set[idx] + 1;
      if (ev[1] && m_set[idx] > lo_v[idx]) m_set[idx] = m_set[idx] - 1;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.st = 3'(m_cur);
    o.pc = 3'(m_set[0]);
    o.qc = 4'(m_set[1]);
    o.at = 7'(m_set[2]);
    o.ws = 7'(m_set[3]);
    o.ss = 4'(m_set[4]);
    o.fs = 4'(m_set[5]);
    o.dn = m_done;
    return o;
  endfunction

  // One clock of stimulus; expected post-edge outputs go into the scoreboard.
  task automatic cyc(input logic [3:0] b, input logic [2:0] v, input logic r);
    @(negedge clk);
    {btn_back, btn_next, btn_down, btn_up} = b;
    view = v;
    rst  = r;
    model_step(b, v, r);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] b);
    cyc(b, 3'd0, 1'b0);
    cyc(4'b0000, 3'd0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs.
  obs_t mon_e, mon_a;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{state, player_count, question_count, answer_time,
                win_score, success_score, fail_score, done};
      checks++;
      txn++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL txn %0d: got st=%0d pc=%0d qc=%0d at=%0d ws=%0d ss=%0d fs=%0d done=%0b expected st=%0d pc=%0d qc=%0d at=%0d ws=%0d ss=%0d fs=%0d done=%0b",
                 txn, mon_a.st, mon_a.pc, mon_a.qc, mon_a.at, mon_a.ws, mon_a.ss, mon_a.fs, mon_a.dn,
                 mon_e.st, mon_e.pc, mon_e.qc, mon_e.at, mon_e.ws, mon_e.ss, mon_e.fs, mon_e.dn);
      end else begin
        $display("txn %0d ok st=%0d pc=%0d qc=%0d at=%0d ws=%0d ss=%0d fs=%0d done=%0b",
                 txn, mon_a.st, mon_a.pc, mon_a.qc, mon_a.at, mon_a.ws, mon_a.ss, mon_a.fs, mon_a.dn);
      end
    end
  end

  initial begin
    logic [3:0] rb;
    logic [2:0] rv;
    logic       rr;
    rst = 1'b1; view = 3'd0;
    btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; btn_back = 1'b0;

    // Reset values
    cyc(4'b0000, 3'd0, 1'b1);
    cyc(4'b0000, 3'd0, 1'b1);
    cyc(4'b0000, 3'd0, 1'b0);
    chk("reset_state", int'(state), 0);
    chk("reset_pc", int'(player_count), 2);
    chk("reset_qc", int'(question_count), 5);
    chk("reset_at", int'(answer_time), 30);
    chk("reset_ws", int'(win_score), 10);
    chk("reset_ss", int'(success_score), 3);
    chk("reset_fs", int'(fail_score), 1);
    chk("reset_done", int'(done), 0);

    // btn_next held through reset must not count until released and pressed again
    cyc(4'b0100, 3'd0, 1'b1);
    cyc(4'b0100, 3'd0, 1'b1);
    repeat (3) cyc(4'b0100, 3'd0, 1'b0);
    chk("held_thru_reset", int'(state), 0);
    cyc(4'b0000, 3'd0, 1'b0);
    press(4'b0100);
    chk("repress_after_reset", int'(state), 1);
    press(4'b1000);

    // answer_time saturation both ways
    repeat (3) press(4'b0100);
    chk("state_time", int'(state), 3);
    repeat (80) press(4'b0001);
    chk("at_sat_hi", int'(answer_time), 99);
    repeat (100) press(4'b0010);
    chk("at_sat_lo", int'(answer_time), 5);

    // Cursor wrap, player_count saturation, done pulse
    press(4'b1000);
    repeat (6) press(4'b0100);
    chk("state_six", int'(state), 6);
    press(4'b0100);
    chk("state_wrap", int'(state), 1);
    repeat (5) press(4'b0001);
    chk("pc_sat_hi", int'(player_count), 4);
    press(4'b1000);
    chk("back_root", int'(state), 0);
    cyc(4'b1000, 3'd0, 1'b0);
    chk("done_pulse", int'(done), 1);
    chk("done_state", int'(state), 0);
    cyc(4'b0000, 3'd0, 1'b0);
    chk("done_one_cycle", int'(done), 0);

    // Simultaneous events
    press(4'b0100);
    press(4'b0100);
    chk("state_two", int'(state), 2);
    press(4'b0011);
    chk("updown_cancel", int'(question_count), 5);
    press(4'b0101);
    chk("next_over_up_state", int'(state), 3);
    chk("next_over_up_qc", int'(question_count), 5);

    // Menu inactive in other views
    cyc(4'b0001, 3'd1, 1'b0);
    cyc(4'b0100, 3'd1, 1'b0);
    cyc(4'b1000, 3'd1, 1'b0);
    cyc(4'b0000, 3'd1, 1'b0);
    chk("view_hold_state", int'(state), 3);
    chk("view_hold_at", int'(answer_time), 5);
    chk("view_done", int'(done), 0);
    cyc(4'b0100, 3'd2, 1'b0);
    cyc(4'b0100, 3'd0, 1'b0);
    cyc(4'b0100, 3'd0, 1'b0);
    chk("view_return_held", int'(state), 3);
    cyc(4'b0000, 3'd0, 1'b0);

    // Random traffic
    repeat (1200) begin
      rb[0] = ($urandom_range(99) < 50);
      rb[1] = ($urandom_range(99) < 45);
      rb[2] = ($urandom_range(99) < 25);
      rb[3] = ($urandom_range(99) < 6);
      rv    = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
      rr    = ($urandom_range(199) == 0);
      cyc(rb, rv, rr);
    end

    // Drain scoreboard with a bounded wait
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
